// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller.
// Shadow entries mirror the destination info of EX and MEM.
package fwd_hazard_ctrl_pkg;

  typedef logic [4:0] RegAddrBus;

  localparam RegAddrBus ZeroReg = 5'd0;

  typedef enum logic [1:0] {
    FH_RUN = 2'd0,
    FH_LU  = 2'd1,
    FH_MW  = 2'd2
  } fh_state_e;

  typedef struct packed {
    logic      v;
    RegAddrBus rd;
    logic      we;
    logic      ld;
  } shadow_t;

  function automatic shadow_t bubble();
    return '0;
  endfunction

endpackage

// File: rtl/fwd_hazard_cmp.sv
// Compares one ID source register against one shadow entry.
// x0 never matches since it is hardwired to zero.
module fwd_hazard_cmp
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic      id_valid,
  input  logic      use_rs,
  input  RegAddrBus rs,
  input  shadow_t   ent,
  output logic      match
);

  assign match = id_valid & use_rs
               & (rs != ZeroReg)
               & ent.v & ent.we
               & (ent.rd == rs);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control: EX/MEM shadows,
// forward flags, load-use and load-wait stalls.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_we_i,
  input  logic             id_is_load_i,
  input  logic [31:0]      ex_result_i,
  input  logic [31:0]      mem_result_i,
  input  logic             mem_data_valid_i,
  output logic             reg1_exforward_flag_o,
  output logic             reg2_exforward_flag_o,
  output logic             reg1_memforward_flag_o,
  output logic             reg2_memforward_flag_o,
  output logic [31:0]      ex_wdata_tem_o,
  output logic [31:0]      mem_wdata_tem_o,
  output logic             stall_id_o,
  output logic             stall_pipe_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MEM_WAIT_MAX);

  shadow_t        ex_q;
  shadow_t        mem_q;
  shadow_t        id_ent;
  fh_state_e      state_q;
  logic [WCW-1:0] wait_q;

  logic m_ex1;
  logic m_ex2;
  logic m_mem1;
  logic m_mem2;
  logic lu_hit;
  logic tmo_exit;
  logic adv;
  logic any_stall;

  assign id_ent = '{
    v:  id_valid_i,
    rd: id_rd_i,
    we: id_we_i,
    ld: id_is_load_i
  };

  fwd_hazard_cmp u_cmp_ex1 (
    .id_valid (id_valid_i),
    .use_rs   (id_rs1_use_i),
    .rs       (id_rs1_i),
    .ent      (ex_q),
    .match    (m_ex1)
  );

  fwd_hazard_cmp u_cmp_ex2 (
    .id_valid (id_valid_i),
    .use_rs   (id_rs2_use_i),
    .rs       (id_rs2_i),
    .ent      (ex_q),
    .match    (m_ex2)
  );

  fwd_hazard_cmp u_cmp_mem1 (
    .id_valid (id_valid_i),
    .use_rs   (id_rs1_use_i),
    .rs       (id_rs1_i),
    .ent      (mem_q),
    .match    (m_mem1)
  );

  fwd_hazard_cmp u_cmp_mem2 (
    .id_valid (id_valid_i),
    .use_rs   (id_rs2_use_i),
    .rs       (id_rs2_i),
    .ent      (mem_q),
    .match    (m_mem2)
  );

  // A load in EX cannot forward yet; the ID op waits one cycle for MEM.
  assign lu_hit   = (m_ex1 | m_ex2) & ex_q.ld;
  assign tmo_exit = (state_q == FH_MW) && (wait_q == WAIT_LIM);

  assign stall_id_o   = lu_hit & ~flush_i;
  assign stall_pipe_o = mem_q.v & mem_q.ld
                      & ~mem_data_valid_i & ~tmo_exit;

  assign reg1_exforward_flag_o  = m_ex1 & ~ex_q.ld & ~flush_i;
  assign reg2_exforward_flag_o  = m_ex2 & ~ex_q.ld & ~flush_i;
  assign reg1_memforward_flag_o = m_mem1 & ~m_ex1 & ~flush_i;
  assign reg2_memforward_flag_o = m_mem2 & ~m_ex2 & ~flush_i;

  assign ex_wdata_tem_o  = ex_result_i;
  assign mem_wdata_tem_o = mem_result_i;

  assign adv       = ~hold_i & ~stall_pipe_o;
  assign any_stall = stall_id_o | stall_pipe_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= bubble();
      mem_q <= bubble();
    end else if (adv) begin
      mem_q <= ex_q;
      if (stall_id_o | flush_i | ~id_valid_i) begin
        ex_q <= bubble();
      end else begin
        ex_q <= id_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FH_RUN;
      wait_q        <= '0;
      timeout_err_o <= 1'b0;
    end else if (!hold_i) begin
      unique case (state_q)
        FH_RUN: begin
          if (stall_pipe_o) begin
            state_q <= FH_MW;
            wait_q  <= WCW'(1);
          end else if (stall_id_o) begin
            state_q <= FH_LU;
          end
        end
        FH_LU: begin
          if (stall_pipe_o) begin
            state_q <= FH_MW;
            wait_q  <= WCW'(1);
          end else begin
            state_q <= FH_RUN;
          end
        end
        FH_MW: begin
          if (mem_data_valid_i) begin
            state_q <= FH_RUN;
            wait_q  <= '0;
          end else if (tmo_exit) begin
            state_q       <= FH_RUN;
            wait_q        <= '0;
            timeout_err_o <= 1'b1;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        default: begin
          state_q <= FH_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Counts through hold so stall cost stays visible while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (any_stall && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
